// File: rtl/exec_unit.sv
// Execution unit: a small issue queue feeding a single-cycle ALU/branch/JALR path
// and an iterative shift-add multiplier; results leave as a one-cycle pulse tagged by ROB id.
module exec_unit #(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 3,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_val1,
    input  logic [XLEN-1:0]  in_val2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ROB_W-1:0] in_entry,
    output logic             out_valid,
    output logic [ROB_W-1:0] out_entry,
    output logic [XLEN-1:0]  out_val,
    output logic             out_jump,
    output logic [XLEN-1:0]  out_pc,
    output logic             dbg_state
);

    // Handshake: an op is taken on an edge where rdy_in && in_valid && in_ready && !flush;
    // in_ready reflects only the registered occupancy, so a same-edge pop never frees a slot early.

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SH = $clog2(XLEN);
    localparam int IW = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BLT   = 5'd12;
    localparam logic [4:0] OP_BGE   = 5'd13;
    localparam logic [4:0] OP_BLTU  = 5'd14;
    localparam logic [4:0] OP_BGEU  = 5'd15;
    localparam logic [4:0] OP_JALR  = 5'd16;
    localparam logic [4:0] OP_MUL   = 5'd17;
    localparam logic [4:0] OP_MULH  = 5'd18;
    localparam logic [4:0] OP_MULHU = 5'd19;

    typedef struct packed {
        logic [4:0]       op;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] entry;
    } q_t;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    q_t               mem [QDEPTH];
    q_t               hd;
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count;
    state_t           state, state_next;
    logic             push, pop, is_mul, mul_done;

    logic [2*XLEN-1:0] acc, mcand, acc_next, corr;
    logic [XLEN-1:0]   mplier;
    logic [IW-1:0]     iter;
    logic              mul_hi;
    logic [ROB_W-1:0]  mul_entry;

    logic [XLEN-1:0]   alu, target;
    logic [SH-1:0]     sh;
    logic              lt_s, lt_u, eq;

    function automatic logic [XLEN-1:0] b2w(input logic b);
        return {{(XLEN-1){1'b0}}, b};
    endfunction

    assign hd        = mem[head];
    assign in_ready  = (count != CW'(QDEPTH));
    assign push      = rdy_in && in_valid && in_ready && !flush;
    assign pop       = rdy_in && !flush && (state == S_IDLE) && (count != '0);
    assign is_mul    = (hd.op == OP_MUL) || (hd.op == OP_MULH) || (hd.op == OP_MULHU);
    assign mul_done  = (state == S_MUL) && (iter == IW'(XLEN - 1));
    assign dbg_state = (state == S_MUL);

    // ---------------- queue ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{op: in_op, v1: in_val1, v2: in_val2, pc: in_pc, entry: in_entry};
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in)      state <= S_IDLE;
        else if (rdy_in) state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pop && is_mul) state_next = S_MUL;
            S_MUL:   if (mul_done)      state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // ---------------- single-cycle datapath ----------------
    assign sh     = hd.v2[SH-1:0];
    assign lt_s   = $signed(hd.v1) < $signed(hd.v2);
    assign lt_u   = hd.v1 < hd.v2;
    assign eq     = hd.v1 == hd.v2;
    assign target = (hd.v1 + hd.v2) & ~XLEN'(1);

    always_comb begin
        alu = '0;
        case (hd.op)
            OP_ADD:  alu = hd.v1 + hd.v2;
            OP_SUB:  alu = hd.v1 - hd.v2;
            OP_SLL:  alu = hd.v1 << sh;
            OP_SLT:  alu = b2w(lt_s);
            OP_SLTU: alu = b2w(lt_u);
            OP_XOR:  alu = hd.v1 ^ hd.v2;
            OP_SRL:  alu = hd.v1 >> sh;
            OP_SRA:  alu = $unsigned($signed(hd.v1) >>> sh);
            OP_OR:   alu = hd.v1 | hd.v2;
            OP_AND:  alu = hd.v1 & hd.v2;
            OP_BEQ:  alu = b2w(eq);
            OP_BNE:  alu = b2w(!eq);
            OP_BLT:  alu = b2w(lt_s);
            OP_BGE:  alu = b2w(!lt_s);
            OP_BLTU: alu = b2w(lt_u);
            OP_BGEU: alu = b2w(!lt_u);
            OP_JALR: alu = hd.pc + XLEN'(4);
            default: alu = '0;
        endcase
    end

    // ---------------- multiplier ----------------
    // The loop is always an unsigned shift-add; for MULH the accumulator is preloaded with
    // the two's-complement sign corrections so the high half comes out signed x signed.
    always_comb begin
        corr = '0;
        if (hd.op == OP_MULH) begin
            if (hd.v1[XLEN-1]) corr = corr - {hd.v2, {XLEN{1'b0}}};
            if (hd.v2[XLEN-1]) corr = corr - {hd.v1, {XLEN{1'b0}}};
        end
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            iter      <= '0;
            mul_hi    <= 1'b0;
            mul_entry <= '0;
        end else if (rdy_in && !flush) begin
            if (pop && is_mul) begin
                acc       <= corr;
                mcand     <= {{XLEN{1'b0}}, hd.v1};
                mplier    <= hd.v2;
                iter      <= '0;
                mul_hi    <= (hd.op != OP_MUL);
                mul_entry <= hd.entry;
            end else if (state == S_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                iter   <= iter + IW'(1);
            end
        end
    end

    // ---------------- result register ----------------
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            out_valid <= 1'b0;
            out_jump  <= 1'b0;
            out_entry <= '0;
            out_val   <= '0;
            out_pc    <= '0;
        end else if (rdy_in) begin
            out_valid <= 1'b0;
            out_jump  <= 1'b0;
            if (!flush) begin
                if (pop && !is_mul) begin
                    out_valid <= 1'b1;
                    out_entry <= hd.entry;
                    out_val   <= alu;
                    if (hd.op == OP_JALR) begin
                        out_jump <= 1'b1;
                        out_pc   <= target;
                    end
                end else if (mul_done) begin
                    out_valid <= 1'b1;
                    out_entry <= mul_entry;
                    out_val   <= mul_hi ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a table of single-cycle op vectors plus hand-written
// sequences for multiply latency, queue full, flush, stall and mid-operation reset.
module tb_exec_unit;

    localparam int XLEN   = 32;
    localparam int ROB_W  = 3;
    localparam int QDEPTH = 4;
    localparam int W      = ROB_W + XLEN;

    logic             clk;
    logic             rst_in;
    logic             rdy_in;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [XLEN-1:0]  in_val1, in_val2, in_pc;
    logic [ROB_W-1:0] in_entry;
    logic             out_valid;
    logic [ROB_W-1:0] out_entry;
    logic [XLEN-1:0]  out_val;
    logic             out_jump;
    logic [XLEN-1:0]  out_pc;
    logic             dbg_state;

    exec_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_val1(in_val1), .in_val2(in_val2), .in_pc(in_pc), .in_entry(in_entry),
        .out_valid(out_valid), .out_entry(out_entry), .out_val(out_val),
        .out_jump(out_jump), .out_pc(out_pc), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [4:0]       op;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] entry;
        logic [XLEN-1:0]  val;
        logic             jump;
        logic [XLEN-1:0]  tgt;
    } vec_t;

    typedef struct {
        logic [4:0]      op;
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        logic [XLEN-1:0] val;
    } mvec_t;

    vec_t  vecs[20];
    mvec_t mvecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [XLEN-1:0] v1,
                            input logic [XLEN-1:0] v2, input logic [XLEN-1:0] pc,
                            input logic [ROB_W-1:0] entry);
        in_valid = 1'b1;
        in_op    = op;
        in_val1  = v1;
        in_val2  = v2;
        in_pc    = pc;
        in_entry = entry;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int t0, input int limit, output logic seen, output int lat);
        while (!out_valid && (cyc - t0) < limit) begin
            @(posedge clk);
            #1;
        end
        seen = out_valid;
        lat  = cyc - t0;
    endtask

    task automatic count_valids(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int   t0, lat, hits, got;
        logic seen;
        logic [W-1:0] e;

        vecs[0]  = '{5'd0,  32'd5,        32'd7,        32'h0,   3'd2, 32'd12,       1'b0, 32'h0};
        vecs[1]  = '{5'd1,  32'd3,        32'd5,        32'h0,   3'd1, 32'hFFFFFFFE, 1'b0, 32'h0};
        vecs[2]  = '{5'd2,  32'd1,        32'h21,       32'h0,   3'd3, 32'd2,        1'b0, 32'h0};
        vecs[3]  = '{5'd3,  32'hFFFFFFFF, 32'd1,        32'h0,   3'd4, 32'd1,        1'b0, 32'h0};
        vecs[4]  = '{5'd3,  32'd1,        32'hFFFFFFFF, 32'h0,   3'd5, 32'd0,        1'b0, 32'h0};
        vecs[5]  = '{5'd4,  32'd1,        32'hFFFFFFFF, 32'h0,   3'd5, 32'd1,        1'b0, 32'h0};
        vecs[6]  = '{5'd5,  32'hF0F0,     32'hFF00,     32'h0,   3'd6, 32'h0FF0,     1'b0, 32'h0};
        vecs[7]  = '{5'd6,  32'h80000000, 32'd4,        32'h0,   3'd7, 32'h08000000, 1'b0, 32'h0};
        vecs[8]  = '{5'd7,  32'h80000000, 32'h24,       32'h0,   3'd0, 32'hF8000000, 1'b0, 32'h0};
        vecs[9]  = '{5'd7,  32'h40000000, 32'd4,        32'h0,   3'd1, 32'h04000000, 1'b0, 32'h0};
        vecs[10] = '{5'd8,  32'hF0,       32'h0F,       32'h0,   3'd1, 32'hFF,       1'b0, 32'h0};
        vecs[11] = '{5'd9,  32'hF0,       32'h3C,       32'h0,   3'd2, 32'h30,       1'b0, 32'h0};
        vecs[12] = '{5'd10, 32'd7,        32'd7,        32'h0,   3'd3, 32'd1,        1'b0, 32'h0};
        vecs[13] = '{5'd11, 32'd7,        32'd7,        32'h0,   3'd4, 32'd0,        1'b0, 32'h0};
        vecs[14] = '{5'd12, 32'd1,        32'hFFFFFFFF, 32'h0,   3'd5, 32'd0,        1'b0, 32'h0};
        vecs[15] = '{5'd13, 32'd5,        32'd5,        32'h0,   3'd6, 32'd1,        1'b0, 32'h0};
        vecs[16] = '{5'd14, 32'd1,        32'hFFFFFFFF, 32'h0,   3'd7, 32'd1,        1'b0, 32'h0};
        vecs[17] = '{5'd15, 32'd1,        32'hFFFFFFFF, 32'h0,   3'd0, 32'd0,        1'b0, 32'h0};
        vecs[18] = '{5'd16, 32'h1001,     32'd4,        32'h200, 3'd1, 32'h204,      1'b1, 32'h1004};
        vecs[19] = '{5'd20, 32'd5,        32'd7,        32'h0,   3'd2, 32'd0,        1'b0, 32'h0};

        mvecs[0] = '{5'd18, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        mvecs[1] = '{5'd19, 32'hFFFFFFFF, 32'd2,        32'd1};
        mvecs[2] = '{5'd17, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE};
        mvecs[3] = '{5'd18, 32'h80000000, 32'h80000000, 32'h40000000};
        mvecs[4] = '{5'd18, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0};

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_val1  = '0;
        in_val2  = '0;
        in_pc    = '0;
        in_entry = '0;

        // reset state
        idle(2);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_val",   64'(out_val),   64'd0);
        check("rst_out_pc",    64'(out_pc),    64'd0);
        check("rst_out_entry", 64'(out_entry), 64'd0);
        check("rst_out_jump",  64'(out_jump),  64'd0);
        rst_in = 1'b0;
        idle(1);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // single-cycle op table: one push into an idle unit, result one cycle later
        for (int i = 0; i < 20; i++) begin
            drive_op(vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].pc, vecs[i].entry);
            check("vec_no_early_valid", 64'(out_valid), 64'd0);
            idle(1);
            check("vec_valid", 64'(out_valid), 64'd1);
            check("vec_val",   64'(out_val),   64'(vecs[i].val));
            check("vec_entry", 64'(out_entry), 64'(vecs[i].entry));
            check("vec_jump",  64'(out_jump),  64'(vecs[i].jump));
            if (vecs[i].jump) check("vec_pc", 64'(out_pc), 64'(vecs[i].tgt));
        end
        idle(1);

        // back-to-back single-cycle ops
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = 5'd0;
            in_val1  = XLEN'(i * 10);
            in_val2  = 32'd1;
            in_entry = ROB_W'(i);
            @(posedge clk);
            #1;
            if (i > 0) begin
                check("b2b_valid", 64'(out_valid), 64'd1);
                check("b2b_val",   64'(out_val),   64'((i - 1) * 10 + 1));
                check("b2b_entry", 64'(out_entry), 64'(i - 1));
            end
        end
        in_valid = 1'b0;
        idle(1);
        check("b2b_last_valid", 64'(out_valid), 64'd1);
        check("b2b_last_val",   64'(out_val),   64'd21);
        idle(1);
        check("b2b_drop_valid", 64'(out_valid), 64'd0);

        // MULH followed immediately by ADD
        drive_op(5'd18, 32'hFFFFFFFF, 32'd2, 32'h0, 3'd3);
        t0 = cyc;
        drive_op(5'd0, 32'd1, 32'd1, 32'h0, 3'd4);
        check("mul_state", 64'(dbg_state), 64'd1);
        wait_valid(t0, 100, seen, lat);
        check("mulh_seen",  64'(seen),      64'd1);
        check("mulh_lat",   64'(lat),       64'(XLEN + 1));
        check("mulh_val",   64'(out_val),   64'hFFFFFFFF);
        check("mulh_entry", 64'(out_entry), 64'd3);
        check("mulh_jump",  64'(out_jump),  64'd0);
        idle(1);
        check("after_mul_valid", 64'(out_valid), 64'd1);
        check("after_mul_val",   64'(out_val),   64'd2);
        check("after_mul_entry", 64'(out_entry), 64'd4);
        idle(1);

        // multiply table
        for (int i = 0; i < 5; i++) begin
            drive_op(mvecs[i].op, mvecs[i].v1, mvecs[i].v2, 32'h0, ROB_W'(i));
            t0 = cyc;
            wait_valid(t0, 100, seen, lat);
            check("mtab_seen", 64'(seen),    64'd1);
            check("mtab_lat",  64'(lat),     64'(XLEN + 1));
            check("mtab_val",  64'(out_val), 64'(mvecs[i].val));
            idle(1);
        end

        // queue fills behind a MUL; the extra op must be refused
        drive_op(5'd17, 32'hFFFFFFFF, 32'd3, 32'h0, 3'd0);
        exp_q.push_back({3'd0, 32'hFFFFFFFD});
        for (int i = 1; i <= QDEPTH; i++) begin
            check("qfill_ready", 64'(in_ready), 64'd1);
            drive_op(5'd0, XLEN'(i * 100), 32'd1, 32'h0, ROB_W'(i));
            exp_q.push_back({ROB_W'(i), XLEN'(i * 100 + 1)});
        end
        check("qfull_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_op    = 5'd0;
        in_val1  = 32'd999;
        in_val2  = 32'd0;
        in_entry = 3'd5;
        idle(2);
        check("qfull_still_low", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    check("qfull_extra_result", 64'(out_entry), 64'd7);
                end else begin
                    e = exp_q.pop_front();
                    check("qfull_result", 64'({out_entry, out_val}), 64'(e));
                end
            end
        end
        check("qfull_count", 64'(got), 64'(QDEPTH + 1));

        // flush mid-MUL with two queued ops and a simultaneous push
        drive_op(5'd17, 32'd5, 32'd5, 32'h0, 3'd1);
        drive_op(5'd0, 32'd1, 32'd1, 32'h0, 3'd2);
        drive_op(5'd0, 32'd2, 32'd2, 32'h0, 3'd3);
        idle(4);
        check("flush_pre_state", 64'(dbg_state), 64'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 5'd0;
        in_entry = 3'd6;
        idle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_ready", 64'(in_ready),  64'd1);
        check("flush_state", 64'(dbg_state), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        count_valids(50, hits);
        check("flush_no_result", 64'(hits), 64'd0);
        drive_op(5'd0, 32'd2, 32'd2, 32'h0, 3'd5);
        idle(1);
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_val",   64'(out_val),   64'd4);
        check("post_flush_entry", 64'(out_entry), 64'd5);
        idle(1);

        // three stalled cycles in the middle of a multiply
        drive_op(5'd19, 32'hFFFFFFFF, 32'd2, 32'h0, 3'd2);
        t0 = cyc;
        idle(5);
        rdy_in = 1'b0;
        idle(3);
        check("stall_state_held", 64'(dbg_state), 64'd1);
        rdy_in = 1'b1;
        wait_valid(t0, 100, seen, lat);
        check("stall_seen", 64'(seen),    64'd1);
        check("stall_lat",  64'(lat),     64'(XLEN + 1 + 3));
        check("stall_val",  64'(out_val), 64'd1);
        idle(1);

        // outputs hold during a stall and the pulse is not repeated afterwards
        drive_op(5'd0, 32'd3, 32'd4, 32'h0, 3'd1);
        idle(1);
        rdy_in = 1'b0;
        idle(2);
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_val",   64'(out_val),   64'd7);
        rdy_in = 1'b1;
        idle(1);
        check("resume_valid", 64'(out_valid), 64'd0);

        // reset in the middle of a multiply
        drive_op(5'd17, 32'd7, 32'd7, 32'h0, 3'd3);
        idle(5);
        rst_in = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_val",   64'(out_val),   64'd0);
        check("midrst_ready", 64'(in_ready),  64'd1);
        check("midrst_state", 64'(dbg_state), 64'd0);
        idle(2);
        rst_in = 1'b0;
        count_valids(40, hits);
        check("midrst_no_result", 64'(hits), 64'd0);
        drive_op(5'd0, 32'd5, 32'd7, 32'h0, 3'd2);
        idle(1);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_val",   64'(out_val),   64'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter ROB_W, default 3, ROB entry-id width.
REQ-003 SHALL have parameter QDEPTH, default 4, input queue depth (power of two, >=2).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; rst_in  in  1  asynchronous active-high reset.
REQ-005 rdy_in  in  1  global enable; low freezes all state.
REQ-006 flush  in  1  misprediction clear.
REQ-007 in_valid  in  1  issue request; in_ready  out  1  queue not full.
REQ-008 in_op  in  5  opcode; in_val1, in_val2  in  XLEN  operands; in_pc  in  XLEN  instruction PC; in_entry  in  ROB_W  ROB id.
REQ-009 out_valid  out  1  result pulse; out_entry  out  ROB_W  ROB id; out_val  out  XLEN  result.
REQ-010 out_jump  out  1  JALR target valid; out_pc  out  XLEN  JALR target.

Function
REQ-011 SHALL decode in_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 JALR, 17 MUL, 18 MULH, 19 MULHU; all other codes SHALL give out_val=0.
REQ-012 SHALL push on edges with rdy_in && in_valid && in_ready && !flush; in_ready = queue not full (a same-cycle pop does not raise it).
REQ-013 Queue SHALL be circular FIFO with head/tail pointers wrapping at QDEPTH and an occupancy counter 0..QDEPTH.
REQ-014 Execute FSM SHALL have states IDLE and MUL; in IDLE with queue non-empty it SHALL pop the head on the next enabled edge.
REQ-015 Single-cycle ops (0-16): on pop edge, register result; out_valid=1 for exactly one enabled cycle; push at edge k -> out_valid high after edge k+1 when queue empty and FSM IDLE.
REQ-016 Back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-017 Shifts SHALL use val2[$clog2(XLEN)-1:0]; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned; SRA arithmetic.
REQ-018 Branch ops SHALL return out_val = 1 if condition true else 0.
REQ-019 JALR SHALL return out_val = in_pc+4, out_pc = (val1+val2) with bit0 cleared, out_jump=1 with out_valid; out_jump=0 for all other results.
REQ-020 MUL ops SHALL pop into MUL state, run a shift-add of exactly XLEN iterations (one per enabled cycle), then return to IDLE asserting out_valid; no pop while in MUL.
REQ-021 MUL returns low XLEN of product; MULH high XLEN of signed x signed; MULHU high XLEN of unsigned x unsigned; arithmetic modulo 2^(2*XLEN).
REQ-022 flush SHALL, on the next enabled edge, empty queue, abort MUL to IDLE, force out_valid=0 and out_jump=0; flush wins over simultaneous push/pop.
REQ-023 rdy_in low SHALL hold queue, FSM, counter and all outputs unchanged (out_valid not re-pulsed on resume).

Reset
REQ-024 rst_in high SHALL immediately clear queue (count 0, pointers 0), FSM to IDLE, iteration counter 0.
REQ-025 During/after reset: out_valid=0, out_jump=0, out_entry=0, out_val=0, out_pc=0, in_ready=1.
REQ-026 Reset asserted mid-MUL SHALL discard the operation with no result emitted.

Verification
REQ-027 ADD 5+7 entry 2 into empty unit -> out_valid one cycle after push, out_val=12, out_entry=2.
REQ-028 SRA 0x80000000 by 0x24 -> out_val=0xF8000000 (shift 4); SLTU 1 vs 0xFFFFFFFF -> 1; BLT same -> 0.
REQ-029 JALR val1=0x1001,val2=4,pc=0x200 -> out_val=0x204, out_pc=0x1004, out_jump=1.
REQ-030 MULH 0xFFFFFFFF x 2 -> 0xFFFFFFFF after XLEN+1 cycles; MULHU same -> 1; MUL -> 0xFFFFFFFE; following ADD emitted next cycle.
REQ-031 Push QDEPTH+1 ops behind a MUL -> in_ready low at QDEPTH, extra op not accepted, all QDEPTH results in order.
REQ-032 flush mid-MUL with 2 queued ops -> no out_valid afterward, in_ready=1, next push executes normally; rdy_in low 3 cycles mid-MUL -> latency extended by exactly 3.
